// File: rtl/cook_timer_datapath.sv
// Egg-timer datapath: BCD MM:SS cook-time setting, 1 s prescaler and a
// saturating BCD countdown copy that reports completion at 00:00.
module cook_timer_datapath #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_mode,
  input  logic       increment_seconds,
  input  logic       increment_minutes,
  input  logic       load_timer,
  input  logic       main_timer_enable,
  output logic [7:0] set_minutes,
  output logic [7:0] set_seconds,
  output logic [7:0] count_minutes,
  output logic [7:0] count_seconds,
  output logic       tick,
  output logic       timer_done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          sec_q;
  logic          min_q;
  logic          sec_edge;
  logic          min_edge;

  // Increment one BCD pair; tens_max bounds the tens digit (5 for seconds, 9 for minutes).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == tens_max) r = '0;
      else                    r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Decrement one BCD pair; only called with a non-zero value.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  assign sec_edge   = increment_seconds & ~sec_q;
  assign min_edge   = increment_minutes & ~min_q;
  assign timer_done = (count_minutes == 8'h00) && (count_seconds == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q       <= 1'b0;
      min_q       <= 1'b0;
      set_seconds <= '0;
      set_minutes <= '0;
    end else begin
      sec_q <= increment_seconds;
      min_q <= increment_minutes;
      if (prog_mode && sec_edge) set_seconds <= bcd_inc(set_seconds, 4'd5);
      if (prog_mode && min_edge) set_minutes <= bcd_inc(set_minutes, 4'd9);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || load_timer) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else if (main_timer_enable) begin
      if (prescaler == PRESC_MAX) begin
        prescaler <= '0;
        tick      <= 1'b1;
      end else begin
        prescaler <= prescaler + PW'(1);
        tick      <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_minutes <= '0;
      count_seconds <= '0;
    end else if (load_timer) begin
      count_minutes <= set_minutes;
      count_seconds <= set_seconds;
    end else if (tick && !timer_done) begin
      if (count_seconds == 8'h00) begin
        count_seconds <= 8'h59;
        count_minutes <= bcd_dec(count_minutes);
      end else begin
        count_seconds <= bcd_dec(count_seconds);
      end
    end
  end

endmodule

// File: tb/tb_cook_timer_datapath.sv
// Directed self-checking bench for cook_timer_datapath with a 4-cycle second.
module tb_cook_timer_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_mode;
  logic       increment_seconds;
  logic       increment_minutes;
  logic       load_timer;
  logic       main_timer_enable;
  logic [7:0] set_minutes;
  logic [7:0] set_seconds;
  logic [7:0] count_minutes;
  logic [7:0] count_seconds;
  logic       tick;
  logic       timer_done;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  cook_timer_datapath #(.TICK_DIV(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .prog_mode        (prog_mode),
    .increment_seconds(increment_seconds),
    .increment_minutes(increment_minutes),
    .load_timer       (load_timer),
    .main_timer_enable(main_timer_enable),
    .set_minutes      (set_minutes),
    .set_seconds      (set_seconds),
    .count_minutes    (count_minutes),
    .count_seconds    (count_seconds),
    .tick             (tick),
    .timer_done       (timer_done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      increment_seconds = 1'b1;
      cyc(1);
      increment_seconds = 1'b0;
      cyc(1);
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      increment_minutes = 1'b1;
      cyc(1);
      increment_minutes = 1'b0;
      cyc(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int load_cyc;
    int ticks_seen;
    int r;
    logic [15:0] prev;

    reset = 1'b1;
    prog_mode = 1'b0;
    increment_seconds = 1'b0;
    increment_minutes = 1'b0;
    load_timer = 1'b0;
    main_timer_enable = 1'b0;

    // Reset state
    cyc(2);
    check("rst_set_min", set_minutes, 8'h00);
    check("rst_set_sec", set_seconds, 8'h00);
    check("rst_cnt_min", count_minutes, 8'h00);
    check("rst_cnt_sec", count_seconds, 8'h00);
    check("rst_tick", tick, 1'b0);
    check("rst_done", timer_done, 1'b1);
    reset = 1'b0;
    cyc(1);

    // Setting 02:03, one minutes request held for 10 cycles
    prog_mode = 1'b1;
    pulse_sec(3);
    check("set_sec_3", set_seconds, 8'h03);
    pulse_min(1);
    increment_minutes = 1'b1;
    cyc(10);
    increment_minutes = 1'b0;
    cyc(1);
    check("set_min_held", set_minutes, 8'h02);
    check("set_sec_held", set_seconds, 8'h03);
    prog_mode = 1'b0;
    pulse_sec(2);
    pulse_min(2);
    check("noprog_min", set_minutes, 8'h02);
    check("noprog_sec", set_seconds, 8'h03);
    increment_seconds = 1'b1;
    cyc(2);
    prog_mode = 1'b1;
    cyc(3);
    check("prehigh_sec", set_seconds, 8'h03);
    increment_seconds = 1'b0;
    cyc(1);

    // Setting wrap
    do_reset();
    pulse_min(2);
    pulse_sec(9);
    check("wrap_sec_09", set_seconds, 8'h09);
    pulse_sec(1);
    check("wrap_sec_10", set_seconds, 8'h10);
    pulse_sec(49);
    check("wrap_sec_59", set_seconds, 8'h59);
    pulse_sec(1);
    check("wrap_sec_00", set_seconds, 8'h00);
    check("wrap_min_kept", set_minutes, 8'h02);
    pulse_min(97);
    check("wrap_min_99", set_minutes, 8'h99);
    pulse_min(1);
    check("wrap_min_00", set_minutes, 8'h00);
    increment_seconds = 1'b1;
    increment_minutes = 1'b1;
    cyc(1);
    increment_seconds = 1'b0;
    increment_minutes = 1'b0;
    cyc(1);
    check("both_min", set_minutes, 8'h01);
    check("both_sec", set_seconds, 8'h01);

    // Countdown from 01:02
    do_reset();
    pulse_min(1);
    pulse_sec(2);
    prog_mode = 1'b0;
    load_timer = 1'b1;
    main_timer_enable = 1'b1;
    cyc(1);
    load_timer = 1'b0;
    load_cyc = cycles;
    check("load_min", count_minutes, 8'h01);
    check("load_sec", count_seconds, 8'h02);
    check("load_done", timer_done, 1'b0);
    prev = {count_minutes, count_seconds};
    for (int k = 1; k <= 62; k++) begin
      for (int w = 0; w < 10 && {count_minutes, count_seconds} == prev; w++) cyc(1);
      r = 62 - k;
      check($sformatf("cd_%0d", r), {count_minutes, count_seconds}, {bcd(r / 60), bcd(r % 60)});
      prev = {count_minutes, count_seconds};
    end
    check("cd_done", timer_done, 1'b1);
    check("cd_latency_ok", ((cycles - load_cyc) >= 246) && ((cycles - load_cyc) <= 250), 1'b1);
    ticks_seen = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      if (tick) ticks_seen++;
    end
    check("sat_ticks", ticks_seen, 20);
    check("sat_count", {count_minutes, count_seconds}, 16'h0000);
    check("sat_done", timer_done, 1'b1);
    main_timer_enable = 1'b0;

    // Pause at 00:45 with prescaler at 2
    do_reset();
    prog_mode = 1'b1;
    pulse_sec(46);
    prog_mode = 1'b0;
    load_timer = 1'b1;
    main_timer_enable = 1'b1;
    cyc(1);
    load_timer = 1'b0;
    cyc(6);
    check("pause_cnt_pre", {count_minutes, count_seconds}, 16'h0045);
    check("pause_presc_pre", dut.prescaler, 2);
    main_timer_enable = 1'b0;
    cyc(50);
    check("pause_cnt", {count_minutes, count_seconds}, 16'h0045);
    check("pause_presc", dut.prescaler, 2);
    check("pause_tick", tick, 1'b0);
    main_timer_enable = 1'b1;
    cyc(1);
    check("resume_tick1", tick, 1'b0);
    cyc(1);
    check("resume_tick2", tick, 1'b1);
    cyc(1);
    check("resume_cnt", {count_minutes, count_seconds}, 16'h0044);
    main_timer_enable = 1'b0;

    // Load coincident with prescaler wrap
    do_reset();
    prog_mode = 1'b1;
    pulse_min(3);
    prog_mode = 1'b0;
    load_timer = 1'b1;
    main_timer_enable = 1'b1;
    cyc(1);
    load_timer = 1'b0;
    cyc(7);
    check("prio_cnt_pre", {count_minutes, count_seconds}, 16'h0259);
    check("prio_presc_pre", dut.prescaler, 3);
    load_timer = 1'b1;
    cyc(1);
    load_timer = 1'b0;
    check("prio_cnt", {count_minutes, count_seconds}, 16'h0300);
    check("prio_tick", tick, 1'b0);
    check("prio_presc", dut.prescaler, 0);
    cyc(1);
    check("prio_cnt_next", {count_minutes, count_seconds}, 16'h0300);
    check("prio_tick_next", tick, 1'b0);
    check("prio_presc_next", dut.prescaler, 1);
    main_timer_enable = 1'b0;

    // Reset mid-countdown at 01:30
    do_reset();
    prog_mode = 1'b1;
    pulse_min(1);
    pulse_sec(30);
    prog_mode = 1'b0;
    load_timer = 1'b1;
    main_timer_enable = 1'b1;
    cyc(1);
    load_timer = 1'b0;
    cyc(2);
    check("mid_cnt", {count_minutes, count_seconds}, 16'h0130);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_cnt", {count_minutes, count_seconds}, 16'h0000);
    check("mid_rst_set", {set_minutes, set_seconds}, 16'h0000);
    check("mid_rst_tick", tick, 1'b0);
    check("mid_rst_done", timer_done, 1'b1);
    check("mid_rst_presc", dut.prescaler, 0);
    reset = 1'b0;
    main_timer_enable = 1'b0;
    cyc(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cook_timer_datapath.md
Name: cook_timer_datapath

Overview:
- Datapath partner of the egg-timer main control FSM. Consumes its `prog_mode`, `increment_seconds`/`increment_minutes`, `load_timer` and `main_timer_enable` strobes, and returns `timer_done`.
- Holds the user-set cook time (BCD MM:SS) and a countdown copy of it.
- Generates the 1 s tick internally and decrements the countdown copy to 00:00.
- Exposes both values for the display driver.

Parameters:
- TICK_DIV, 100000000, clk cycles per countdown second (≥2; bench overrides to a small value).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- prog_mode  input  1  setting counters may be incremented
- increment_seconds  input  1  level request, already debounced and synchronous to clk
- increment_minutes  input  1  level request, same conditioning
- load_timer  input  1  one-cycle strobe: copy setting into countdown
- main_timer_enable  input  1  countdown may run
- set_minutes  output  8  BCD setting minutes {tens,ones}, 00–99
- set_seconds  output  8  BCD setting seconds {tens,ones}, 00–59
- count_minutes  output  8  BCD countdown minutes
- count_seconds  output  8  BCD countdown seconds
- tick  output  1  one-cycle pulse when a countdown second elapses
- timer_done  output  1  countdown value is 00:00

Behaviour:

Clocking and reset
- Single clock domain. All state updates on the `clk` rising edge.
- `reset` high at an edge clears, on that edge, all of the following: setting regs, countdown regs, prescaler, edge-detect history, and `tick`. It overrides every other input.
- Reset values: set_minutes = set_seconds = count_minutes = count_seconds = 8'h00; tick = 0; timer_done = 1.

Setting counters
- A rising edge of `increment_seconds` is its registered previous value 0 and its current value 1.
- Each rising edge with `prog_mode` = 1 advances `set_seconds` by 1 in BCD.
  - Ones digit wraps 9→0 and carries into the tens digit.
  - 59 wraps to 00 with no carry into minutes.
- A held-high request increments exactly once.
- `increment_minutes` works the same way on `set_minutes`; 99 wraps to 00.
- Simultaneous seconds and minutes edges are both applied in the same cycle.
- With `prog_mode` = 0, edges are ignored but the history register still updates. A request already high when `prog_mode` rises therefore does not increment.
- Result visible one cycle after the rising edge.

Prescaler and tick
- Counter range 0..TICK_DIV-1. Advances only while `main_timer_enable` = 1.
- When `main_timer_enable` = 0 it holds its value; it is not cleared.
- `tick` is registered, high for exactly one cycle when the prescaler wraps from TICK_DIV-1 to 0 while enabled.
- `load_timer` clears the prescaler to 0 and suppresses `tick` that cycle.

Countdown
- Priority, highest first: reset, load_timer, tick-decrement.
- On `load_timer`: count ← set, visible next cycle. `prog_mode` is ignored.
- On `tick`, with count ≠ 00:00: decrement one second in BCD.
  - Seconds ones digit 0→9 borrows from the tens digit.
  - Seconds 00 → 59 borrows one minute.
- At 00:00 a tick has no effect: the count saturates and never wraps to 99:59.
- Decrement latency: count changes on the edge after the one where `tick` is asserted. Total from load to 00:00 is N×TICK_DIV cycles plus at most 2.

timer_done
- Combinational from the count registers: 1 iff count_minutes = count_seconds = 0.
- After reset it reads 1, so the controller moves to its DONE state.

Data integrity
- No digit ever holds a value above 9.
- No seconds tens digit ever holds a value above 5.

Test Plan:
1. Reset check: assert reset 2 cycles → all BCD outputs 8'h00, tick = 0, timer_done = 1. Repeat with reset asserted mid-countdown at 01:30 → all outputs 8'h00 and timer_done = 1 on the next edge.
2. Setting: prog_mode = 1, three separate seconds pulses plus two minutes pulses, one of them held high 10 cycles → set 02:03. With prog_mode = 0, further pulses leave 02:03.
3. Setting wrap: prog_mode = 1, 60 seconds pulses from 00 → set_seconds = 8'h00 and set_minutes unchanged. 100 minutes pulses → set_minutes = 8'h00. Pulses 9 and 10 yield 8'h09 then 8'h10.
4. Countdown, with TICK_DIV = 4: set 01:02, load, enable → 01:01, 01:00, 00:59, …, 00:00.
   - timer_done rises 62×4 (±2) cycles after load.
   - 20 further ticks keep the count at 00:00 with timer_done = 1.
5. Pause and resume: drop enable at 00:45 with prescaler at 2 for 50 cycles → count and prescaler hold. Re-enable → next tick after 2 cycles.
6. Priority: assert load_timer in the same cycle the prescaler wraps with set = 03:00 → count = 03:00, no decrement, tick low, prescaler = 0.
